// File: rtl/d_fifo_drain_arbiter_pkg.sv
// Shared definitions for the D0/D1 FIFO drain arbiter.
// Optional feature macro: STRICT_PRIO_D0_EN (D0 strict priority instead of round robin).
package d_fifo_drain_arbiter_pkg;

  localparam int unsigned DataWidth = 6;
  localparam int unsigned BufDepth  = 2;

  // Source tag carried alongside each drained word
  typedef enum logic {
    DestD0 = 1'b0,
    DestD1 = 1'b1
  } dest_e;

  // Words either buffered or already requested from a FIFO
  function automatic logic [1:0] occupancy(input logic [1:0] count, input logic inflight);
    return count + {1'b0, inflight};
  endfunction

endpackage

// File: rtl/d_fifo_drain_arbiter_if.sv
// FIFO-side and output-stream signals of the drain arbiter.
// master: the arbiter; slave: FIFOs plus downstream consumer.
interface d_fifo_drain_arbiter_if #(
  parameter int unsigned data_width = 6
);
  logic                  enable;
  logic                  empty_fifo_D0;
  logic                  empty_fifo_D1;
  logic [data_width-1:0] data_out_D0;
  logic [data_width-1:0] data_out_D1;
  logic                  D0_pop;
  logic                  D1_pop;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_data;
  logic                  out_dest;

  modport master (
    input  enable, empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, out_ready,
    output D0_pop, D1_pop, out_valid, out_data, out_dest
  );

  modport slave (
    output enable, empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, out_ready,
    input  D0_pop, D1_pop, out_valid, out_data, out_dest
  );
endinterface

// File: rtl/d_fifo_drain_arbiter_out_buf2.sv
// Two-entry FIFO holding {dest, data} words between FIFO read and the output stream.
module d_fifo_drain_arbiter_out_buf2 #(
  parameter int unsigned Width = 7
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [1:0]       count_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ok;

  // Next-state: write at wr_ptr, pop at rd_ptr, count tracks the difference
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rd_ok    = rd_en_i && (count_q != 2'd0);
    if (wr_en_i) begin
      mem_d[wr_ptr_q] = wr_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (rd_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({wr_en_i, rd_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset clears contents so the head reads zero
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // The issue rule upstream must make overflow impossible
  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(wr_en_i && !rd_ok && count_q == 2'd2));
  a_count_range: assert property (@(posedge clk_i) disable iff (reset_i) count_q != 2'd3);

endmodule

// File: rtl/d_fifo_drain_arbiter.sv
// Drains the D0/D1 FIFOs onto one valid/ready stream, tagging each word with its source.
// Round robin by default; define STRICT_PRIO_D0_EN for D0 strict priority.
module d_fifo_drain_arbiter
  import d_fifo_drain_arbiter_pkg::*;
#(
  parameter int unsigned data_width = DataWidth
) (
  input logic                  clk,
  input logic                  reset,
  d_fifo_drain_arbiter_if.master bus
);

  logic                  inflight_q, inflight_d;
  dest_e                 inflight_src_q, inflight_src_d;
  dest_e                 rr_last_q, rr_last_d;
  logic [1:0]            buf_count;
  logic [data_width:0]   buf_head;
  logic [data_width:0]   wr_data;
  logic                  pop_d0, pop_d1;
  logic                  can_issue, elig_d0, elig_d1, grant_d1;

  // Arbitration and pop strobes from registered state and current empty flags
  always_comb begin
    elig_d0   = !bus.empty_fifo_D0;
    elig_d1   = !bus.empty_fifo_D1;
    // Occupancy is taken before this cycle's dequeue, so back-pressure can never overflow
    can_issue = !reset && bus.enable && (occupancy(buf_count, inflight_q) < 2'(BufDepth));
`ifdef STRICT_PRIO_D0_EN
    grant_d1  = elig_d1 && !elig_d0;
`else
    grant_d1  = elig_d1 && (!elig_d0 || rr_last_q == DestD0);
`endif
    pop_d1    = can_issue && grant_d1;
    pop_d0    = can_issue && elig_d0 && !grant_d1;

    inflight_d     = pop_d0 || pop_d1;
    inflight_src_d = pop_d1 ? DestD1 : DestD0;
    rr_last_d      = rr_last_q;
    if (pop_d0 || pop_d1) begin
      rr_last_d = inflight_src_d;
    end

    wr_data = {inflight_src_q, (inflight_src_q == DestD1) ? bus.data_out_D1 : bus.data_out_D0};
  end

  // In-flight tracking and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q     <= 1'b0;
      inflight_src_q <= DestD0;
      rr_last_q      <= DestD1;
    end else begin
      inflight_q     <= inflight_d;
      inflight_src_q <= inflight_src_d;
      rr_last_q      <= rr_last_d;
    end
  end

  d_fifo_drain_arbiter_out_buf2 #(
    .Width (data_width + 1)
  ) u_out_buf2 (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (inflight_q),
    .wr_data_i (wr_data),
    .rd_en_i   (bus.out_valid && bus.out_ready),
    .count_o   (buf_count),
    .head_o    (buf_head)
  );

  assign bus.D0_pop    = pop_d0;
  assign bus.D1_pop    = pop_d1;
  assign bus.out_valid = (buf_count != 2'd0);
  assign bus.out_data  = buf_head[data_width-1:0];
  assign bus.out_dest  = buf_head[data_width];

endmodule

// File: tb/tb_d_fifo_drain_arbiter.sv
// Directed bench for d_fifo_drain_arbiter with behavioural read-latency-1 FIFO models.
module tb_d_fifo_drain_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  d_fifo_drain_arbiter_if #(.data_width(6)) bus ();

  d_fifo_drain_arbiter #(.data_width(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] d0_rd = '0;
  logic [5:0] d1_rd = '0;
  int         obs[$];
  int         pop_log[$];
  int         n_pops;
  int         cyc;
  int         first_pop_cyc;
  int         first_valid_cyc;
  int         n_vec;
  int         n_err;

  assign bus.empty_fifo_D0 = (q0.size() == 0);
  assign bus.empty_fifo_D1 = (q1.size() == 0);
  assign bus.data_out_D0   = d0_rd;
  assign bus.data_out_D1   = d1_rd;

  // FIFO models and output monitor, evaluated on pre-edge values
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (bus.D0_pop && q0.size() > 0) begin
        d0_rd <= q0.pop_front();
        n_pops = n_pops + 1;
        pop_log.push_back(0);
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      if (bus.D1_pop && q1.size() > 0) begin
        d1_rd <= q1.pop_front();
        n_pops = n_pops + 1;
        pop_log.push_back(1);
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.out_valid && bus.out_ready) obs.push_back({23'd0, bus.out_dest, 2'b00, bus.out_data});
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_obs(input string tag, input int n, input int budget);
    int k = 0;
    while (obs.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_count"}, obs.size(), n);
  endtask

  // Assert reset and clear all bench bookkeeping; caller loads FIFOs, then releases reset
  task automatic reset_on();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    obs.delete();
    pop_log.delete();
    n_pops = 0;
    first_pop_cyc = -1;
    first_valid_cyc = -1;
    tick(2);
  endtask

  function automatic int w(input int dest, input int data);
    return (dest << 8) | data;
  endfunction

  int exp3[4];
  int expp[4];
  int snap;

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    n_pops = 0;
    first_pop_cyc = -1;
    first_valid_cyc = -1;
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.out_ready = 1'b1;

    // Reset held with inputs active, then D0-only drain
    q0.push_back(6'h05);
    q0.push_back(6'h06);
    q0.push_back(6'h0E);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_pop", {bus.D1_pop, bus.D0_pop}, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.out_data, 0);
    end
    check("rst_no_pop_cnt", n_pops, 0);
    reset = 1'b0;
    #1;
    check("first_pop", {bus.D1_pop, bus.D0_pop}, 1);
    wait_obs("d0only", 3, 30);
    check("d0only_w0", obs[0], w(0, 6'h05));
    check("d0only_w1", obs[1], w(0, 6'h06));
    check("d0only_w2", obs[2], w(0, 6'h0E));
    check("d0only_pops", n_pops, 3);
    check("latency", first_valid_cyc - first_pop_cyc, 2);

    // Both sources non-empty
    reset_on();
    q0.push_back(6'h04);
    q0.push_back(6'h05);
    q1.push_back(6'h02);
    q1.push_back(6'h03);
    reset = 1'b0;
`ifdef STRICT_PRIO_D0_EN
    exp3 = '{w(0, 6'h04), w(0, 6'h05), w(1, 6'h02), w(1, 6'h03)};
    expp = '{0, 0, 1, 1};
`else
    exp3 = '{w(0, 6'h04), w(1, 6'h02), w(0, 6'h05), w(1, 6'h03)};
    expp = '{0, 1, 0, 1};
`endif
    wait_obs("arb", 4, 40);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("arb_w%0d", i), (obs.size() > i) ? obs[i] : -1, exp3[i]);
      check($sformatf("arb_pop%0d", i), (pop_log.size() > i) ? pop_log[i] : -1, expp[i]);
    end

    // Back-pressure: two pops fill the buffer, head holds
    reset_on();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) q0.push_back(6'(8'h11 + i));
    reset = 1'b0;
    tick(3);
    check("bp_head_a", bus.out_data, 6'h11);
    check("bp_valid_a", bus.out_valid, 1);
    tick(2);
    check("bp_head_b", bus.out_data, 6'h11);
    check("bp_dest_b", bus.out_dest, 0);
    check("bp_pops", n_pops, 2);
    check("bp_no_pop", bus.D0_pop, 0);
    bus.out_ready = 1'b1;
    wait_obs("bp", 4, 40);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_w%0d", i), (obs.size() > i) ? obs[i] : -1, w(0, 8'h11 + i));
    end
    check("bp_pops_total", n_pops, 4);

    // enable dropped the cycle after a pop
    reset_on();
    bus.enable = 1'b0;
    q0.push_back(6'h21);
    q0.push_back(6'h22);
    reset = 1'b0;
    tick(1);
    check("en_off_pop", bus.D0_pop, 0);
    bus.enable = 1'b1;
    tick(1);
    bus.enable = 1'b0;
    tick(6);
    check("en_drop_cnt", obs.size(), 1);
    check("en_drop_w0", (obs.size() > 0) ? obs[0] : -1, w(0, 6'h21));
    check("en_drop_pops", n_pops, 1);
    bus.enable = 1'b1;
    wait_obs("en_resume", 2, 20);
    check("en_resume_w1", (obs.size() > 1) ? obs[1] : -1, w(0, 6'h22));
    check("en_resume_pops", n_pops, 2);

    // Reset while the buffer is full
    reset_on();
    bus.out_ready = 1'b0;
    q0.push_back(6'h31);
    q0.push_back(6'h32);
    q0.push_back(6'h33);
    reset = 1'b0;
    tick(4);
    check("full_pops", n_pops, 2);
    check("full_valid", bus.out_valid, 1);
    reset = 1'b1;
    tick(1);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_data", bus.out_data, 0);
    snap = n_pops;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    wait_obs("midrst", 1, 20);
    tick(4);
    check("midrst_w0", (obs.size() > 0) ? obs[0] : -1, w(0, 6'h33));
    check("midrst_drained", obs.size(), n_pops - snap);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
